// File: rtl/mdu_wb_queue.sv
// In-order writeback queue for MDU results (result word, decode info, operands).
// Optional same-cycle bypass when empty is enabled by defining MDU_WB_BYPASS_EN.
module mdu_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DI_W   = 64,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_W-1:0]         in_res_i,
    input  logic [DI_W-1:0]           in_di_i,
    input  logic [2*DATA_W-1:0]       in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_W-1:0]         out_res_o,
    output logic [DI_W-1:0]           out_di_o,
    output logic [2*DATA_W-1:0]       out_data_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]       rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [DATA_W-1:0]   res_q  [DEPTH];
    logic [DI_W-1:0]     di_q   [DEPTH];
    logic [2*DATA_W-1:0] data_q [DEPTH];

    logic push, pop, wr_en, rd_en, bypass_take, empty;

    assign empty      = (count_q == '0);
    assign in_ready_o = (count_q < CW'(DEPTH)) & ~flush;
    assign count_o    = count_q;

`ifdef MDU_WB_BYPASS_EN
    // While empty the head is the incoming result itself.
    assign out_valid_o = empty ? (in_valid_i & ~flush) : ~flush;
    assign out_res_o   = empty ? in_res_i  : res_q[rptr_q];
    assign out_di_o    = empty ? in_di_i   : di_q[rptr_q];
    assign out_data_o  = empty ? in_data_i : data_q[rptr_q];
`else
    assign out_valid_o = ~empty & ~flush;
    assign out_res_o   = res_q[rptr_q];
    assign out_di_o    = di_q[rptr_q];
    assign out_data_o  = data_q[rptr_q];
`endif

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

`ifdef MDU_WB_BYPASS_EN
    // A result consumed straight through never touches the storage.
    assign bypass_take = empty & pop;
`else
    assign bypass_take = 1'b0;
`endif

    assign wr_en = push & ~bypass_take;
    assign rd_en = pop & ~bypass_take;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + PW'(1);
            if (rd_en) rptr_d = rptr_q + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage is intentionally not reset; contents only matter while counted.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            res_q[wptr_q]  <= in_res_i;
            di_q[wptr_q]   <= in_di_i;
            data_q[wptr_q] <= in_data_i;
        end
    end
endmodule

// File: tb/tb_mdu_wb_queue.sv
// Directed self-checking bench for mdu_wb_queue at default parameters.
module tb_mdu_wb_queue;
    logic         clk = 1'b0;
    logic         rst, flush, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [31:0]  in_res_i, out_res_o;
    logic [63:0]  in_di_i, out_di_o, in_data_i, out_data_o;
    logic [2:0]   count_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_wb_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_res_i(in_res_i), .in_di_i(in_di_i), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_res_o(out_res_o), .out_di_o(out_di_o), .out_data_o(out_data_o),
        .count_o(count_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge, then settle so checks sample away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic ordy);
        in_valid_i  = v;
        in_res_i    = r;
        in_di_i     = {32'hD1D1_0000, r};
        in_data_i   = {r, ~r};
        out_ready_i = ordy;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        step(); step();
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_count", count_o, 0);
        rst = 1'b0;
        step();
        chk("post_rst_count", count_o, 0);

        // single push, visible next cycle (same cycle with bypass)
        drive(1'b1, 32'h5, 1'b1);
`ifdef MDU_WB_BYPASS_EN
        chk("bypass_same_valid", out_valid_o, 1);
        chk("bypass_same_res", out_res_o, 32'h5);
        step();
        drive(1'b0, 32'h0, 1'b1);
        chk("bypass_count", count_o, 0);
`else
        chk("lat1_same_valid", out_valid_o, 0);
        step();
        drive(1'b0, 32'h0, 1'b1);
        chk("lat1_valid", out_valid_o, 1);
        chk("lat1_res", out_res_o, 32'h5);
        chk("lat1_di", out_di_o, 64'hD1D1_0000_0000_0005);
        chk("lat1_count", count_o, 1);
        step();
`endif
        chk("drain1_count", count_o, 0);
        chk("drain1_valid", out_valid_o, 0);

        // fill to DEPTH
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b0);
            step();
        end
        chk("full_count", count_o, 4);
        chk("full_in_ready", in_ready_o, 0);
        drive(1'b1, 32'h5, 1'b0);
        step();
        chk("full_reject_count", count_o, 4);
        chk("full_head", out_res_o, 32'h1);

        // drain in order; push attempt during first pop must be refused
        for (int i = 1; i <= 4; i++) begin
            drive(i == 1, 32'h99, 1'b1);
            if (i == 1) chk("full_pop_in_ready", in_ready_o, 0);
            chk($sformatf("drain_valid%0d", i), out_valid_o, 1);
            chk($sformatf("drain_res%0d", i), out_res_o, 32'(i));
            step();
            if (i == 1) chk("full_pop_count", count_o, 3);
        end
        drive(1'b0, 32'h0, 1'b0);
        chk("drained_count", count_o, 0);
        chk("drained_valid", out_valid_o, 0);

        // count=2, six simultaneous push/pop cycles across the wrap
        drive(1'b1, 32'h10, 1'b0); step();
        drive(1'b1, 32'h11, 1'b0); step();
        chk("pp_pre_count", count_o, 2);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'hA0 + 32'(k), 1'b1);
            chk($sformatf("pp_head%0d", k), out_res_o,
                (k == 0) ? 32'h10 : (k == 1) ? 32'h11 : 32'hA0 + 32'(k - 2));
            step();
            chk($sformatf("pp_count%0d", k), count_o, 2);
        end
        drive(1'b0, 32'h0, 1'b1);
        chk("pp_tail0", out_res_o, 32'hA4); step();
        chk("pp_tail1", out_res_o, 32'hA5); step();
        chk("pp_empty", count_o, 0);

        // count=DEPTH-1 simultaneous push/pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(i), 1'b0); step();
        end
        drive(1'b1, 32'h33, 1'b1);
        chk("d1_in_ready", in_ready_o, 1);
        step();
        chk("d1_count", count_o, 3);
        chk("d1_head", out_res_o, 32'h31);
        // flush with count=3 and a same-cycle push
        drive(1'b1, 32'h66, 1'b0);
        flush = 1'b1; #1;
        chk("flush_in_ready", in_ready_o, 0);
        chk("flush_out_valid", out_valid_o, 0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("flush_count", count_o, 0);
        chk("flush_valid", out_valid_o, 0);
        drive(1'b1, 32'h77, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0);
        chk("post_flush_count", count_o, 1);
        chk("post_flush_head", out_res_o, 32'h77);

        // rst + flush + push with count=2
        drive(1'b1, 32'h88, 1'b0); step();
        chk("rf_pre_count", count_o, 2);
        rst = 1'b1; flush = 1'b1;
        drive(1'b1, 32'h99, 1'b1);
        step();
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        chk("rf_count", count_o, 0);
        chk("rf_in_ready", in_ready_o, 1);
        chk("rf_out_valid", out_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_wb_queue.md
MDU_WB_QUEUE -- requirements
Module: mdu_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries; legal values are powers of two from 2 to 8.
REQ-002 SHALL have parameter DI_W, default 64, width of the decode-info bundle carried alongside each result.
REQ-003 SHALL have parameter DATA_W, default 32, machine word width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-006 SHALL have port flush, input, 1 bit, the pipeline flush; all queued entries are discarded.
REQ-007 SHALL have port in_valid_i, input, 1 bit, MDU result valid.
REQ-008 SHALL have port in_ready_o, output, 1 bit, queue can accept a result.
REQ-009 SHALL have port in_res_i, input, DATA_W bits, the MDU result word.
REQ-010 SHALL have port in_di_i, input, DI_W bits, the decode info of the result.
REQ-011 SHALL have port in_data_i, input, 2*DATA_W bits, the source operands, kept for debug/commit.
REQ-012 SHALL have port out_valid_o, output, 1 bit, head entry valid towards writeback.
REQ-013 SHALL have port out_ready_i, input, 1 bit, writeback accepts the head entry.
REQ-014 SHALL have ports out_res_o, out_di_o and out_data_o, outputs, widths as the matching inputs, the head entry fields.
REQ-015 SHALL have port count_o, output, clog2(DEPTH)+1 bits, current occupancy.

Function
REQ-016 SHALL be an in-order FIFO; a push occurs on in_valid_i & in_ready_o, and a pop occurs on out_valid_o & out_ready_i.
REQ-017 SHALL drive in_ready_o = (count < DEPTH) & ~flush, with no combinational dependence on out_ready_i.
REQ-018 SHALL drive out_valid_o = (count != 0) & ~flush when bypass is absent.
REQ-019 SHALL give a latency of 1 cycle without bypass: an entry pushed in cycle N is visible at the head in cycle N+1 at the earliest.
REQ-020 SHALL update count on simultaneous push and pop as follows: count is unchanged, both pointers advance, and data order is preserved; this also applies at count == DEPTH-1 and at count == 1.
REQ-021 SHALL leave in_ready_o deasserted when full (count == DEPTH), even if a pop occurs in the same cycle; accepting the push in that cycle is not allowed.
REQ-022 SHALL keep out_valid_o deasserted when empty, and shall keep out_* held stable while out_valid_o is asserted and out_ready_i is low.
REQ-023 SHALL use read/write pointers of clog2(DEPTH) bits that wrap modulo DEPTH; full/empty are determined from count only.
REQ-024 SHALL, on flush, set the pointers and count to 0 at the next edge; no push or pop occurs in the flush cycle, and any same-cycle in_valid_i is dropped.
REQ-025 SHALL not reset the entry storage; out_* are don't-care whenever out_valid_o is 0.

Reset
REQ-026 SHALL, when rst is high at a clock edge, set read pointer = 0, write pointer = 0 and count = 0.
REQ-027 SHALL hold outputs during and after reset until the first push at in_ready_o = 1, out_valid_o = 0 and count_o = 0.
REQ-028 SHALL discard all entries when rst is asserted mid-operation, including any push or pop in that cycle; rst has priority over flush.

Configuration
REQ-029 SHALL support macro MDU_WB_BYPASS_EN; when it is defined and count == 0, out_valid_o = in_valid_i & ~flush and out_* = in_* combinationally.
REQ-030 SHALL, in bypass, require that a same-cycle pop with an empty queue performs no write, leaving count at 0; if out_ready_i is low, the input is pushed normally.
REQ-031 SHALL, when the macro is undefined, provide no combinational in_*-to-out_* path and a fixed minimum latency of 1 cycle.

Verification
REQ-032 SHALL cover: reset, then push res=0x0000_0005, out_ready_i=1 -> out_valid_o high the next cycle with out_res_o=0x5; with bypass, high the same cycle.
REQ-033 SHALL cover: 4 pushes 0x1..0x4 with out_ready_i=0 -> count_o=4, in_ready_o=0, and a 5th push 0x5 is not accepted.
REQ-034 SHALL cover: full, then out_ready_i=1 for 4 cycles -> pops 0x1,0x2,0x3,0x4 in order, then count_o=0 and out_valid_o=0.
REQ-035 SHALL cover: count=2, simultaneous push 0xA and pop for 6 cycles -> count_o stays 2, order preserved across pointer wrap.
REQ-036 SHALL cover: count=3, flush together with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, and the flushed-cycle result never appears.
REQ-037 SHALL cover: rst asserted in the same cycle as flush with count=2 and a push -> next cycle count_o=0 and in_ready_o=1.
